// File: rtl/vfu_wb_arbiter_pkg.sv
// Shared write-back types: source encoding and the per-slice result record.
package vfu_wb_arbiter_pkg;

  localparam int unsigned WbIdWidth   = 3;
  localparam int unsigned WbAddrWidth = 10;
  localparam int unsigned WbElen      = 64;

  typedef enum logic {
    WbAlu  = 1'b0,
    WbMfpu = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WbIdWidth-1:0]   id;
    logic [WbAddrWidth-1:0] addr;
    logic [WbElen-1:0]      wdata;
    logic [WbElen/8-1:0]    be;
  } wb_slice_t;

  // The source that gets priority after the given one has been written.
  function automatic wb_src_e wb_other(input wb_src_e src);
    return (src == WbAlu) ? WbMfpu : WbAlu;
  endfunction

endpackage

// File: rtl/vfu_wb_slice_buf.sv
// Single-entry holding buffer for one SIMD slice result of one functional unit.
module vfu_wb_slice_buf
  import vfu_wb_arbiter_pkg::*;
#(
  parameter type slice_t = wb_slice_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   req_i,
  input  slice_t slice_i,
  input  logic   drain_i,
  output logic   gnt_o,
  output logic   held_o,
  output slice_t slice_o
);

  logic   held_q;
  slice_t slice_q;
  logic   capture;

  // A slice is accepted when the entry is empty or is being written out this cycle.
  assign gnt_o   = !held_q || drain_i || !rst_ni;
  assign capture = req_i && gnt_o;
  assign held_o  = held_q;
  assign slice_o = slice_q;

  // Valid bit: a re-capture in the drain cycle keeps the entry occupied.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      held_q <= 1'b0;
    end else if (capture) begin
      held_q <= 1'b1;
    end else if (drain_i) begin
      held_q <= 1'b0;
    end
  end

  // Payload register, only loaded on capture; not reset since held_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      slice_q <= slice_i;
    end
  end

endmodule

// File: rtl/vfu_wb_arbiter.sv
// Collects per-slice ALU/MFPU results, merges full units and arbitrates the VRF write port.
module vfu_wb_arbiter
  import vfu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrSimd    = 2,
  parameter int unsigned Elen      = 64,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned IdWidth   = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [1:0][NrSimd-1:0]                 slc_req_i,
  input  logic [1:0][NrSimd-1:0][IdWidth-1:0]    slc_id_i,
  input  logic [1:0][NrSimd-1:0][AddrWidth-1:0]  slc_addr_i,
  input  logic [1:0][NrSimd-1:0][Elen-1:0]       slc_wdata_i,
  input  logic [1:0][NrSimd-1:0][Elen/8-1:0]     slc_be_i,
  output logic [1:0][NrSimd-1:0]                 slc_gnt_o,
  output logic                                   vrf_req_o,
  output logic [IdWidth-1:0]                     vrf_id_o,
  output logic [AddrWidth-1:0]                   vrf_addr_o,
  output logic [NrSimd*Elen-1:0]                 vrf_wdata_o,
  output logic [NrSimd*Elen/8-1:0]               vrf_be_o,
  output logic                                   vrf_src_o,
  input  logic                                   vrf_gnt_i,
  output logic                                   mismatch_o
);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [Elen-1:0]      wdata;
    logic [Elen/8-1:0]    be;
  } slice_t;

  slice_t                  slc_in [2][NrSimd];
  slice_t                  slc_q  [2][NrSimd];
  logic [1:0][NrSimd-1:0]  held;
  logic [1:0]              full;
  logic [1:0]              drain;

  wb_src_e sel;
  wb_src_e lock_src_q;
  wb_src_e prio_q;
  logic    lock_q;
  logic    mismatch_q;
  logic    slice_diff;

  for (genvar u = 0; u < 2; u++) begin : gen_unit
    localparam wb_src_e Src = (u == 0) ? WbAlu : WbMfpu;

    assign full[u]  = &held[u];
    assign drain[u] = vrf_req_o && vrf_gnt_i && (sel == Src);

    for (genvar i = 0; i < NrSimd; i++) begin : gen_slice
      assign slc_in[u][i] = {slc_id_i[u][i], slc_addr_i[u][i], slc_wdata_i[u][i], slc_be_i[u][i]};

      vfu_wb_slice_buf #(
        .slice_t (slice_t)
      ) i_slice_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (slc_req_i[u][i]),
        .slice_i (slc_in[u][i]),
        .drain_i (drain[u]),
        .gnt_o   (slc_gnt_o[u][i]),
        .held_o  (held[u][i]),
        .slice_o (slc_q[u][i])
      );
    end
  end

  // Source selection: a stalled request keeps its source, otherwise priority breaks ties.
  always_comb begin
    sel = WbAlu;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (full[0] && full[1]) begin
      sel = prio_q;
    end else if (full[1]) begin
      sel = WbMfpu;
    end
  end

  assign vrf_req_o  = rst_ni && full[sel];
  assign vrf_src_o  = rst_ni && (sel == WbMfpu);
  assign mismatch_o = rst_ni && (mismatch_q || (vrf_req_o && slice_diff));

  // Merge the selected unit's slices and compare their id/addr against slice 0.
  always_comb begin
    vrf_id_o    = slc_q[sel][0].id;
    vrf_addr_o  = slc_q[sel][0].addr;
    vrf_wdata_o = '0;
    vrf_be_o    = '0;
    slice_diff  = 1'b0;
    for (int i = 0; i < NrSimd; i++) begin
      vrf_wdata_o[Elen*i +: Elen]     = slc_q[sel][i].wdata;
      vrf_be_o[(Elen/8)*i +: Elen/8]  = slc_q[sel][i].be;
      if ((slc_q[sel][i].id != slc_q[sel][0].id) || (slc_q[sel][i].addr != slc_q[sel][0].addr)) begin
        slice_diff = 1'b1;
      end
    end
  end

  // Arbitration state: lock on a stalled request, rotate priority on every write, sticky mismatch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= WbAlu;
      prio_q     <= WbAlu;
      mismatch_q <= 1'b0;
    end else begin
      if (|drain) begin
        lock_q <= 1'b0;
        prio_q <= wb_other(sel);
      end else if (vrf_req_o && !vrf_gnt_i) begin
        lock_q     <= 1'b1;
        lock_src_q <= sel;
      end
      if (vrf_req_o && slice_diff) begin
        mismatch_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vfu_wb_arbiter.md
# vfu_wb_arbiter

Write-back scheduler between the per-lane functional-unit stage and the lane's vector register file (VRF) write port. It collects the per-SIMD-slice results that the replicated ALU and MFPU slices emit independently and holds each one until all slices of that unit have produced a result. It then merges the slices into one full-width word and arbitrates round-robin between the ALU and the MFPU for the single VRF write port. Each slice gets its own grant, so slices that produce results at different cycles never deadlock the unit.

## Interface
Parameters:
- NrSimd, 2: number of ELEN-wide slices per unit.
- Elen, 64: slice data width in bits.
- AddrWidth, 10: VRF address width.
- IdWidth, 3: instruction id width.

Ports (u = 0 for ALU, u = 1 for MFPU):
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- slc_req_i  in  [2][NrSimd]  per-slice result valid.
- slc_id_i  in  [2][NrSimd][IdWidth]  slice instruction id.
- slc_addr_i  in  [2][NrSimd][AddrWidth]  slice VRF address.
- slc_wdata_i  in  [2][NrSimd][Elen]  slice data.
- slc_be_i  in  [2][NrSimd][Elen/8]  slice byte enables.
- slc_gnt_o  out  [2][NrSimd]  per-slice accept.
- vrf_req_o  out  1  merged write request.
- vrf_id_o  out  IdWidth  id of the merged word.
- vrf_addr_o  out  AddrWidth  address of the merged word.
- vrf_wdata_o  out  NrSimd*Elen  merged data; slice i occupies bits [Elen*(i+1)-1 : Elen*i].
- vrf_be_o  out  NrSimd*Elen/8  merged byte enables, packed the same way as the data.
- vrf_src_o  out  1  source of the current request: 0 = ALU, 1 = MFPU.
- vrf_gnt_i  in  1  VRF accepts the merged word.
- mismatch_o  out  1  sticky slice id/address mismatch flag.

## Operation
- Holding registers: one per (unit, slice), each with a valid bit held[u][i] plus the id, addr, wdata and be of the captured slice.
- Capture: a slice is captured when slc_req_i and slc_gnt_o are both high in the same cycle.
- Slice grant: slc_gnt_o[u][i] = !held[u][i] | drain[u], where drain[u] = (vrf_req_o && vrf_src_o == u && vrf_gnt_i). This allows back-to-back words at full throughput.
- Unit completion: full[u] = AND over all slices of held[u][i].
- Request: vrf_req_o = full[sel], where sel is the selected source.
- Arbitration:
  - Registered `lock` bit and `lock_src`. While lock = 1, sel = lock_src and the source cannot change.
  - While lock = 0 and both units are full, sel = prio. While lock = 0 and only one unit is full, sel = that unit.
  - Lock is set when vrf_req_o is high and vrf_gnt_i is low (lock_src = sel). Lock is cleared on drain.
- Round-robin priority: on every drain, prio <= !vrf_src_o.
- Drain effect: the drained unit's held bits clear in the next cycle, unless the same slice is re-captured in the drain cycle, in which case held stays 1 and holds the new data.
- Merge: vrf_id_o and vrf_addr_o come from slice 0 of sel. vrf_wdata_o and vrf_be_o are the concatenation of the selected unit's slices.
- Mismatch: if any slice's id or addr differs from slice 0 while vrf_req_o is high, mismatch_o is set. It stays set until reset. The write still proceeds using slice 0's id and addr.
- Byte enables are passed through unmodified; a slice with be = 0 still counts as held.

## Timing
- Reset (rst_ni low at a clock edge): all held bits = 0, lock = 0, prio = 0 (ALU first), mismatch_o = 0.
- Output values while in reset: vrf_req_o = 0, vrf_src_o = 0, all slc_gnt_o = 1.
- Reset mid-operation: held words are discarded; no write is issued for them.
- Latency: the last slice captured at cycle t gives vrf_req_o high at cycle t+1. The path to vrf_req_o is registered; there is no combinational path from slc_req_i.
- VRF handshake: once vrf_req_o is asserted, the request and all its payload stay stable until vrf_gnt_i. vrf_gnt_i is ignored while vrf_req_o is low.
- Slice handshake: a slice may hold slc_req_i high for any number of cycles; it is accepted exactly once.
- Simultaneous completion: if both units become full in the same cycle, prio decides. The loser stays full, with its slice grants low, and is written on the next drain.
- Starvation bound: a full unit waits at most one write of the other unit.

## Structure
- Shared package (ara_pkg) additions:
  - wb_src_e enum: WbAlu = 0, WbMfpu = 1.
  - wb_slice_t struct: id, addr, wdata, be.
- One sub-module, vfu_wb_slice_buf: a single-entry slice holding buffer with capture/drain, instantiated 2*NrSimd times.
- Arbiter and merge logic live in the top module.
- Expected size: about 200 lines of RTL.

## Test plan
- Staggered slices: ALU slice 0 (addr 0x12, id 3, data 0xA…A, be 0xFF) at cycle 0, slice 1 at cycle 4 → vrf_req_o rises at cycle 5 with addr 0x12, id 3, src 0, wdata = {slice1, slice0}, be 0xFFFF; slice 0 grant low during cycles 1–4.
- Tie: both units fill in the same cycle after reset, vrf_gnt_i held high → ALU written first, MFPU next cycle, prio = 0 afterwards.
- Backpressure lock: MFPU full, vrf_gnt_i low for 5 cycles, ALU fills at cycle 2 → src stays 1 and payload stays stable until the grant; ALU written next.
- Streaming: all slices of ALU request every cycle, vrf_gnt_i = 1 → one write per cycle after a 1-cycle latency, slices granted every cycle.
- Mismatch: slice 1 addr 0x13 vs slice 0 addr 0x12 → mismatch_o = 1 from the request cycle, write uses addr 0x12, flag persists until rst_ni = 0.
- Reset mid-operation: ALU half-full and MFPU locked, rst_ni low for 1 cycle → all outputs return to their reset values and no write is issued afterwards.
